// File: rtl/feature_pkg.sv
// Shared constants and state encoding for the feature byte packer.
package feature_pkg;

  localparam int FEATURE_DIM     = 8192;
  localparam int BYTES_PER_WORD  = 16;
  localparam int WORDS_PER_FRAME = FEATURE_DIM / BYTES_PER_WORD;
  localparam int WORD_W          = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo_fwft.sv
// First-word-fall-through FIFO: rd_data shows the head entry while empty is low.
module word_fifo_fwft #(
  parameter int Width = 128,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthLvl = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DepthLvl);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; rd_data is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/feature_packer.sv
// Packs a per-object feature byte stream into fixed-size frames of 128-bit words,
// zero-padding short frames and dropping the tail of long ones.
module feature_packer
  import feature_pkg::*;
#(
  parameter int FeatureDim = FEATURE_DIM,
  parameter int FifoDepth  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   InData,
  input  logic                         InValid,
  input  logic                         InLast,
  output logic                         InReady,
  output logic [WORD_W-1:0]            RdData,
  output logic                         RdEmpty,
  input  logic                         RdFIFO,
  output logic                         FrameDone,
  output logic                         FrameShort,
  output logic                         FrameLong,
  output logic [$clog2(FifoDepth):0]   Level
);

  localparam int Words = FeatureDim / BYTES_PER_WORD;
  localparam int WcW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int LvlW  = $clog2(FifoDepth) + 1;
  localparam logic [WcW-1:0]  LastWord = WcW'(Words - 1);
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(FifoDepth);

  state_t            state_q, state_d;
  logic [3:0]        lane_q, lane_d;
  logic [WcW-1:0]    word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d, asm_wr, push_word;
  logic              ready_en_q;
  logic              long_seen_q, long_seen_d;
  logic              done_q, done_d, short_q, short_d, long_q, long_d;
  logic              push, pop, fifo_full, accept, last_word;

  // Input is held off until the first edge after reset release.
  assign InReady   = ready_en_q && ((state_q == DROP) || ((state_q == FILL) && (Level < DepthLvl)));
  assign accept    = InValid && InReady;
  assign pop       = RdFIFO && !RdEmpty;
  assign last_word = (word_cnt_q == LastWord);

  always_comb begin
    asm_wr = asm_q;
    asm_wr[{lane_q, 3'b000} +: 8] = InData;
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_cnt_d  = word_cnt_q;
    asm_d       = asm_q;
    long_seen_d = long_seen_q;
    push        = 1'b0;
    push_word   = asm_q;
    done_d      = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          asm_d  = asm_wr;
          lane_d = lane_q + 4'd1;
          if (lane_q == 4'd15) begin
            push      = 1'b1;
            push_word = asm_wr;
            asm_d     = '0;
            if (last_word) begin
              word_cnt_d = '0;
              done_d     = 1'b1;
              state_d    = InLast ? FILL : DROP;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              if (InLast) state_d = PAD;
            end
          end else if (InLast) begin
            // Partial word stays in asm_q; its unwritten lanes are already zero.
            state_d = PAD;
            lane_d  = '0;
          end
        end
      end
      PAD: begin
        if (!fifo_full || pop) begin
          push  = 1'b1;
          asm_d = '0;
          if (last_word) begin
            word_cnt_d = '0;
            done_d     = 1'b1;
            short_d    = 1'b1;
            state_d    = FILL;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept) begin
          long_d      = !long_seen_q;
          long_seen_d = 1'b1;
          if (InLast) begin
            long_seen_d = 1'b0;
            state_d     = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      lane_q      <= '0;
      word_cnt_q  <= '0;
      asm_q       <= '0;
      ready_en_q  <= 1'b0;
      long_seen_q <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      word_cnt_q  <= word_cnt_d;
      asm_q       <= asm_d;
      ready_en_q  <= 1'b1;
      long_seen_q <= long_seen_d;
      done_q      <= done_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  assign FrameDone  = done_q;
  assign FrameShort = short_q;
  assign FrameLong  = long_q;

  word_fifo_fwft #(
    .Width (WORD_W),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (RdFIFO),
    .rd_data   (RdData),
    .full      (fifo_full),
    .empty     (RdEmpty),
    .level     (Level)
  );

endmodule

// File: tb/tb_feature_packer.sv
// Self-checking bench for feature_packer: random frames against a frame-level reference model.
module tb_feature_packer;

  localparam int FD    = 8192;
  localparam int WPF   = FD / 16;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   InData;
  logic         InValid, InLast, InReady;
  logic [127:0] RdData;
  logic         RdEmpty, RdFIFO;
  logic         FrameDone, FrameShort, FrameLong;
  logic [3:0]   Level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   frm[$];
  logic [127:0] exp_q[$];
  logic [127:0] got[$];
  int           done_at[$];
  int           acc;
  bit           gap_en;
  int           rd_mode   = 0;
  int           pop_limit = 0;
  int           done_cnt, short_cnt, short_alone, long_cnt, long_at, bytes_in;
  bit           rd;
  int           base_g, base_d, base_s, base_l, base_da, base_b;

  feature_packer #(.FeatureDim(FD), .FifoDepth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .InData     (InData),
    .InValid    (InValid),
    .InLast     (InLast),
    .InReady    (InReady),
    .RdData     (RdData),
    .RdEmpty    (RdEmpty),
    .RdFIFO     (RdFIFO),
    .FrameDone  (FrameDone),
    .FrameShort (FrameShort),
    .FrameLong  (FrameLong),
    .Level      (Level)
  );

  always #5 clk = ~clk;

  // Consumer and pulse monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (FrameDone === 1'b1) begin
      done_cnt++;
      done_at.push_back(got.size() + int'(Level));
    end
    if (FrameShort === 1'b1) begin
      short_cnt++;
      if (FrameDone !== 1'b1) short_alone++;
    end
    if (FrameLong === 1'b1) begin
      long_cnt++;
      long_at = bytes_in;
    end
    if (InValid === 1'b1 && InReady === 1'b1) bytes_in++;
    case (rd_mode)
      1:       rd = 1'b1;
      2:       rd = 1'($urandom_range(0, 1));
      3:       rd = (got.size() < pop_limit);
      default: rd = 1'b0;
    endcase
    RdFIFO = rd;
    if (rd && RdEmpty === 1'b0) got.push_back(RdData);
  end

  task automatic make_frame(input int n, input bit random);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(random ? 8'($urandom) : 8'(i % 256));
  endtask

  // Reference: the first FD bytes of the frame, zero-filled, cut into 16-byte little-endian words.
  task automatic model_expect();
    logic [127:0] w;
    exp_q.delete();
    for (int k = 0; k < WPF; k++) begin
      w = '0;
      for (int b = 0; b < 16; b++)
        if (k * 16 + b < frm.size()) w[8*b +: 8] = frm[k * 16 + b];
      exp_q.push_back(w);
    end
  endtask

  task automatic take_bases();
    base_g  = got.size();
    base_d  = done_cnt;
    base_s  = short_cnt;
    base_l  = long_cnt;
    base_da = done_at.size();
    base_b  = bytes_in;
    acc     = 0;
  endtask

  task automatic drive(input int upto, input int max_cycles);
    int cyc = 0;
    while (acc < upto && cyc < max_cycles) begin
      @(posedge clk); #1;
      InValid = gap_en ? ($urandom_range(0, 7) != 0) : 1'b1;
      InData  = frm[acc];
      InLast  = (acc == frm.size() - 1);
      @(negedge clk);
      if (InValid && InReady) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic wait_words(input int n, input int max_cycles);
    for (int c = 0; c < max_cycles && got.size() - base_g < n; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; InValid = 1'b0; InData = '0; InLast = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL reset_inready: got %b want 0", InReady); end
    n_checks++; if (RdEmpty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", RdEmpty); end
    n_checks++; if (Level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", Level); end
    n_checks++; if (RdData !== 128'd0) begin n_fail++; $display("FAIL reset_rddata: got %h want 0", RdData); end
    n_checks++; if ({FrameDone, FrameShort, FrameLong} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {FrameDone, FrameShort, FrameLong}); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL release_inready: got %b want 1", InReady); end
  endtask

  task automatic test_full_frame();
    logic [127:0] w0;
    make_frame(FD, 1'b0); model_expect(); take_bases();
    rd_mode = 1; gap_en = 1'b0;
    drive(frm.size(), 3 * FD);
    wait_words(WPF, 4000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL full_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    w0 = (got.size() > base_g) ? got[base_g] : 'x;
    n_checks++; if (w0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin n_fail++; $display("FAIL full_word0_const: got %h", w0); end
    n_checks++; if (done_cnt - base_d != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - base_d); end
    n_checks++; if (done_at.size() > base_da && done_at[base_da] - base_g != WPF) begin
      n_fail++; $display("FAIL full_done_word: got %0d want %0d", done_at[base_da] - base_g, WPF); end
    n_checks++; if (short_cnt != base_s || long_cnt != base_l) begin
      n_fail++; $display("FAIL full_no_short_long: got short %0d long %0d want 0 0", short_cnt - base_s, long_cnt - base_l); end
    n_checks++; if (Level !== 4'd0 || RdEmpty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got level %0d empty %b", Level, RdEmpty); end
  endtask

  task automatic test_backpressure();
    make_frame(FD, 1'b1); model_expect(); take_bases();
    rd_mode = 0; gap_en = 1'b0;
    drive(frm.size(), 400);
    n_checks++; if (acc != 128) begin n_fail++; $display("FAIL bp_accepted: got %0d want 128", acc); end
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL bp_inready_full: got %b want 0", InReady); end
    n_checks++; if (Level !== 4'd8 || RdEmpty !== 1'b0) begin n_fail++; $display("FAIL bp_full_level: got level %0d empty %b want 8 0", Level, RdEmpty); end
    pop_limit = got.size() + 1; rd_mode = 3;
    @(posedge clk); #1;
    n_checks++; if (Level !== 4'd7) begin n_fail++; $display("FAIL bp_pop_level: got %0d want 7", Level); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL bp_pop_inready: got %b want 1", InReady); end
    rd_mode = 2; gap_en = 1'b1;
    drive(frm.size(), 4 * FD);
    wait_words(WPF, 4000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - base_d != 1 || short_cnt != base_s || long_cnt != base_l) begin
      n_fail++; $display("FAIL bp_pulses: got done %0d short %0d long %0d want 1 0 0", done_cnt - base_d, short_cnt - base_s, long_cnt - base_l); end
  endtask

  task automatic test_short_frame();
    logic [127:0] w1;
    make_frame(20, 1'b1); model_expect(); take_bases();
    rd_mode = 1; gap_en = 1'b1;
    drive(frm.size(), 200);
    wait_words(WPF, 3000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL short_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL short_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    w1 = (got.size() > base_g + 1) ? got[base_g + 1] : 'x;
    n_checks++; if (w1 !== {96'd0, frm[19], frm[18], frm[17], frm[16]}) begin
      n_fail++; $display("FAIL short_word1_lanes: got %h want %h", w1, {96'd0, frm[19], frm[18], frm[17], frm[16]}); end
    n_checks++; if (done_cnt - base_d != 1 || short_cnt - base_s != 1 || short_alone != 0) begin
      n_fail++; $display("FAIL short_pulses: got done %0d short %0d unpaired %0d want 1 1 0", done_cnt - base_d, short_cnt - base_s, short_alone); end
    n_checks++; if (done_at.size() > base_da && done_at[base_da] - base_g != WPF) begin
      n_fail++; $display("FAIL short_done_word: got %0d want %0d", done_at[base_da] - base_g, WPF); end
    n_checks++; if (long_cnt != base_l) begin n_fail++; $display("FAIL short_no_long: got %0d want 0", long_cnt - base_l); end
  endtask

  task automatic test_pad_full();
    logic [127:0] w0;
    make_frame(20, 1'b1); model_expect(); take_bases();
    rd_mode = 0; gap_en = 1'b0;
    drive(frm.size(), 100);
    for (int c = 0; c < 50 && Level != 4'd8; c++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (Level !== 4'd8) begin n_fail++; $display("FAIL pad_full_level: got %0d want 8", Level); end
    n_checks++; if (done_cnt != base_d) begin n_fail++; $display("FAIL pad_early_done: got %0d want 0", done_cnt - base_d); end
    pop_limit = got.size() + 1; rd_mode = 3;
    @(posedge clk); #1;
    n_checks++; if (Level !== 4'd8) begin n_fail++; $display("FAIL pad_pushpop_level: got %0d want 8", Level); end
    w0 = (got.size() > base_g) ? got[base_g] : 'x;
    n_checks++; if (w0 !== exp_q[0]) begin n_fail++; $display("FAIL pad_pop_word0: got %h want %h", w0, exp_q[0]); end
    rd_mode = 2;
    wait_words(WPF, 3000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL pad_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL pad_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - base_d != 1 || short_cnt - base_s != 1) begin
      n_fail++; $display("FAIL pad_pulses: got done %0d short %0d want 1 1", done_cnt - base_d, short_cnt - base_s); end
  endtask

  task automatic test_long_frame();
    make_frame(FD + 8, 1'b1); model_expect(); take_bases();
    rd_mode = 2; gap_en = 1'b0;
    drive(frm.size(), 3 * FD);
    wait_words(WPF, 4000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL long_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL long_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    n_checks++; if (long_cnt - base_l != 1) begin n_fail++; $display("FAIL long_pulse_cnt: got %0d want 1", long_cnt - base_l); end
    n_checks++; if (long_at - base_b != FD + 1) begin n_fail++; $display("FAIL long_pulse_byte: got %0d want %0d", long_at - base_b - 1, FD); end
    n_checks++; if (bytes_in - base_b != FD + 8) begin n_fail++; $display("FAIL long_accepted: got %0d want %0d", bytes_in - base_b, FD + 8); end
    n_checks++; if (done_cnt - base_d != 1 || short_cnt != base_s) begin
      n_fail++; $display("FAIL long_done: got done %0d short %0d want 1 0", done_cnt - base_d, short_cnt - base_s); end
    // The frame after a truncated one must start on lane 0.
    make_frame(33, 1'b1); model_expect(); take_bases();
    drive(frm.size(), 300);
    wait_words(WPF, 3000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL after_long_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < 4 && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL after_long_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    make_frame(FD, 1'b1); take_bases();
    rd_mode = 2; gap_en = 1'b0;
    drive(37, 200);
    reset = 1'b0;
    #1;
    n_checks++; if (RdEmpty !== 1'b1 || Level !== 4'd0) begin n_fail++; $display("FAIL midreset_fifo: got empty %b level %0d want 1 0", RdEmpty, Level); end
    n_checks++; if (InReady !== 1'b0 || RdData !== 128'd0) begin n_fail++; $display("FAIL midreset_outputs: got ready %b data %h", InReady, RdData); end
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    make_frame(FD, 1'b1); model_expect(); take_bases();
    rd_mode = 2; gap_en = 1'b1;
    drive(frm.size(), 4 * FD);
    wait_words(WPF, 4000);
    n_checks++; if (got.size() - base_g != WPF) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", got.size() - base_g, WPF); end
    for (int i = 0; i < WPF && i < got.size() - base_g; i++) begin
      n_checks++; if (got[base_g + i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_word%0d: got %h want %h", i, got[base_g + i], exp_q[i]); end
    end
    n_checks++; if (done_cnt - base_d != 1 || short_cnt != base_s || long_cnt != base_l) begin
      n_fail++; $display("FAIL midreset_pulses: got done %0d short %0d long %0d want 1 0 0", done_cnt - base_d, short_cnt - base_s, long_cnt - base_l); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_pad_full();
    test_long_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
